rand_range_sampler: RTL and testbench

- Consumes the 16-bit pseudo-random word stream from the LFSR stage.
- Produces values uniformly distributed in [0, limit) by mask-and-reject sampling.
- Accepted values are buffered in a small FIFO and offered downstream on a valid/ready handshake, e.g. to sprite placement or game logic.
- Counts rejected words for debug and statistics.

---
 rtl/rnd_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/rand_range_sampler.sv | 85 ++++++++
 tb/tb_rand_range_sampler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rnd_pkg
// Description : Shared constants, FSM state type and mask helper for the
//               random range sampler.
// Revision    : 1.0
// ============================================================================
package rnd_pkg;

    localparam int c_DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest 2^k-1 covering limit-1; limit=1 yields 0.
    function automatic logic [31:0] mask_fill(input logic [31:0] limit);
        logic [31:0] m;
        m = limit - 32'd1;
        for (int i = 0; i < 5; i++) begin
            m = m | (m >> (1 << i));
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Small synchronous FIFO with a registered head output and a
//               synchronous clear.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign count  = r_count;
    assign dout   = r_dout;

    always_ff @(posedge clk_in) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Keep the head register pointing at the next entry after a pop.
            if (w_pop) begin
                if (r_count > c_CW'(1)) begin
                    r_dout <= r_mem[r_rd_ptr + 1'b1];
                end else if (w_push) begin
                    r_dout <= din;
                end
            end else if (w_push && empty) begin
                r_dout <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rand_range_sampler
// Description : Mask-and-reject sampler turning LFSR words into uniform values
//               in [0, limit), buffered for a valid/ready consumer.
// Revision    : 1.0
// ============================================================================
module rand_range_sampler
    import rnd_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 4,
    parameter int REJ_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] rnd_in,
    input  logic              rnd_valid_in,
    input  logic              cfg_valid_in,
    input  logic [DATA_W-1:0] limit_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy_out,
    output logic [REJ_W-1:0]  rej_count_out
);

    state_t                    r_state;
    logic [DATA_W-1:0]         r_limit;
    logic [DATA_W-1:0]         r_mask;
    logic [REJ_W-1:0]          r_rej;
    logic [DATA_W-1:0]         w_masked;
    logic                      w_sample;
    logic                      w_accept;
    logic                      w_reject;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(DEPTH):0]    w_count;

    assign w_masked = rnd_in & r_mask;
    // A full FIFO drops the word outright: neither pushed nor counted.
    assign w_sample = (r_state == RUN) && rnd_valid_in && !cfg_valid_in && !w_full;
    assign w_accept = w_sample && (w_masked < r_limit);
    assign w_reject = w_sample && !(w_masked < r_limit);
    assign w_pop    = out_ready && !w_empty;

    assign out_valid     = (w_count != '0);
    assign busy_out      = (r_state == RUN);
    assign rej_count_out = r_rej;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_limit <= '0;
            r_mask  <= '0;
            r_rej   <= '0;
        end else if (cfg_valid_in) begin
            r_limit <= limit_in;
            r_mask  <= DATA_W'(mask_fill(32'(limit_in)));
            r_rej   <= '0;
            r_state <= (limit_in != '0) ? RUN : IDLE;
        end else if (w_reject && (r_rej != '1)) begin
            r_rej <= r_rej + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (cfg_valid_in),
        .push   (w_accept),
        .pop    (w_pop),
        .din    (w_masked),
        .dout   (out_data),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_range_sampler
// Description : Directed, table-driven checks for rand_range_sampler.
// Revision    : 1.0
// ============================================================================
module tb_rand_range_sampler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] rnd_in;
    logic        rnd_valid_in;
    logic        cfg_valid_in;
    logic [15:0] limit_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy_out;
    logic [15:0] rej_count_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        cfg;
        logic [15:0] limit;
        logic        rv;
        logic [15:0] rnd;
        logic        rdy;
        logic        ev;
        logic        cd;
        logic [15:0] ed;
        logic        eb;
        logic [15:0] er;
    } vec_t;

    vec_t tbl[$];

    always #5 clk_in = ~clk_in;

    rand_range_sampler #(
        .DATA_W (16),
        .DEPTH  (4),
        .REJ_W  (16)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rnd_in        (rnd_in),
        .rnd_valid_in  (rnd_valid_in),
        .cfg_valid_in  (cfg_valid_in),
        .limit_in      (limit_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy_out      (busy_out),
        .rej_count_out (rej_count_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic add(input logic cfg, input logic [15:0] limit, input logic rv,
                       input logic [15:0] rnd, input logic rdy, input logic ev,
                       input logic cd, input logic [15:0] ed, input logic eb,
                       input logic [15:0] er);
        vec_t v;
        v.cfg = cfg; v.limit = limit; v.rv = rv; v.rnd = rnd; v.rdy = rdy;
        v.ev = ev; v.cd = cd; v.ed = ed; v.eb = eb; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic cfg, input logic [15:0] limit, input logic rv,
                         input logic [15:0] rnd, input logic rdy);
        cfg_valid_in = cfg;
        limit_in     = limit;
        rnd_valid_in = rv;
        rnd_in       = rnd;
        out_ready    = rdy;
    endtask

    initial begin
        int seen_out;
        rst_in = 1'b1;
        drive(0, 0, 0, 0, 0);

        // limit 10: 3 accepted, 0xC rejected, 0xFFF9 -> 9 accepted
        add(1, 16'd10, 0, 16'h0000, 1, 0, 0, 0, 1, 0);
        add(0, 0,      1, 16'h0003, 1, 1, 1, 3, 1, 0);
        add(0, 0,      1, 16'h000C, 1, 0, 0, 0, 1, 1);
        add(0, 0,      1, 16'hFFF9, 1, 1, 1, 9, 1, 1);
        add(0, 0,      0, 16'h0000, 1, 0, 0, 0, 1, 1);
        // limit 1: every word maps to 0
        add(1, 16'd1,  0, 16'h0000, 1, 0, 0, 0, 1, 0);
        add(0, 0,      1, 16'hA5A5, 1, 1, 1, 0, 1, 0);
        add(0, 0,      1, 16'h1234, 1, 1, 1, 0, 1, 0);
        add(0, 0,      1, 16'hFFFF, 1, 1, 1, 0, 1, 0);
        add(0, 0,      1, 16'h8001, 1, 1, 1, 0, 1, 0);
        add(0, 0,      1, 16'h7E7E, 1, 1, 1, 0, 1, 0);
        add(0, 0,      0, 16'h0000, 1, 0, 0, 0, 1, 0);
        // limit 16 with back-pressure: fill, drop two, then drain
        add(1, 16'd16, 0, 16'h0000, 0, 0, 0, 0, 1, 0);
        add(0, 0,      1, 16'h0001, 0, 1, 1, 1, 1, 0);
        add(0, 0,      1, 16'h0002, 0, 1, 1, 1, 1, 0);
        add(0, 0,      1, 16'h0003, 0, 1, 1, 1, 1, 0);
        add(0, 0,      1, 16'h0004, 0, 1, 1, 1, 1, 0);
        add(0, 0,      1, 16'h0005, 0, 1, 1, 1, 1, 0);
        add(0, 0,      1, 16'h0006, 0, 1, 1, 1, 1, 0);
        add(0, 0,      0, 16'h0000, 1, 1, 1, 2, 1, 0);
        add(0, 0,      0, 16'h0000, 1, 1, 1, 3, 1, 0);
        add(0, 0,      0, 16'h0000, 1, 1, 1, 4, 1, 0);
        add(0, 0,      0, 16'h0000, 1, 0, 0, 0, 1, 0);
        // limit 0xFFFF: only 0xFFFF is rejected
        add(1, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 0, 1, 0);
        add(0, 0,      1, 16'hFFFE, 1, 1, 1, 16'hFFFE, 1, 0);
        add(0, 0,      1, 16'hFFFF, 1, 0, 0, 0, 1, 1);
        add(0, 0,      0, 16'h0000, 1, 0, 0, 0, 1, 1);

        #13;
        check("reset valid", out_valid, 0);
        check("reset busy", busy_out, 0);
        check("reset rej", rej_count_out, 0);
        check("reset data", out_data, 0);
        tick();
        rst_in = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].cfg, tbl[i].limit, tbl[i].rv, tbl[i].rnd, tbl[i].rdy);
            tick();
            check($sformatf("row%0d valid", i), out_valid, tbl[i].ev);
            check($sformatf("row%0d busy", i), busy_out, tbl[i].eb);
            check($sformatf("row%0d rej", i), rej_count_out, tbl[i].er);
            if (tbl[i].cd) check($sformatf("row%0d data", i), out_data, tbl[i].ed);
        end

        // Two entries buffered, then limit 0 disables and flushes
        drive(1, 16'd16, 0, 0, 0); tick();
        drive(0, 0, 1, 16'h0005, 0); tick();
        drive(0, 0, 1, 16'h0007, 0); tick();
        check("pre-disable data", out_data, 16'h0005);
        drive(1, 16'd0, 0, 0, 0); tick();
        check("disable valid", out_valid, 0);
        check("disable busy", busy_out, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 16'h0002, 1); tick();
            check($sformatf("disabled word%0d valid", k), out_valid, 0);
        end

        // Asynchronous reset in the middle of a cycle with data pending
        drive(1, 16'd10, 0, 0, 0); tick();
        drive(0, 0, 1, 16'h000F, 0); tick();
        drive(0, 0, 1, 16'h0002, 0); tick();
        check("pre-reset valid", out_valid, 1);
        check("pre-reset data", out_data, 16'h0002);
        check("pre-reset rej", rej_count_out, 1);
        drive(0, 0, 0, 0, 0);
        #3 rst_in = 1'b1;
        #1;
        check("async rst valid", out_valid, 0);
        check("async rst busy", busy_out, 0);
        check("async rst rej", rej_count_out, 0);
        tick();
        rst_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 16'h0001, 1); tick();
            check($sformatf("post-rst word%0d valid", k), out_valid, 0);
            check($sformatf("post-rst word%0d busy", k), busy_out, 0);
        end

        // Reject-counter saturation: limit 3, mask 3, word 3 always rejected
        drive(1, 16'd3, 0, 0, 1); tick();
        seen_out = 0;
        for (int k = 0; k < 32'h10010; k++) begin
            drive(0, 0, 1, 16'h0003, 1); tick();
            if (out_valid) seen_out++;
            if (k == 32'hFFFD) check("rej before saturation", rej_count_out, 16'hFFFE);
        end
        check("rej saturated", rej_count_out, 16'hFFFF);
        check("saturation no outputs", seen_out, 0);
        check("saturation busy", busy_out, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
